axi_stream_packet_cutter: RTL and testbench
===========================================

AXI_STREAM_PACKET_CUTTER -- requirements
Module: axi_stream_packet_cutter

Interface
REQ-001 Parameter DSIZE, default 8, tdata width in bits.
REQ-002 Parameter MAX_LEN, default 16384, maximum beats per output segment, legal range 1..2^20; sized at or below the downstream long-FIFO depth.
REQ-003 Port aclk  input  1  single clock; all logic on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Ports s_tdata/s_tvalid/s_tlast  input  DSIZE/1/1  upstream AXI-Stream beat.
REQ-006 Port s_tready  output  1  upstream ready.
REQ-007 Ports m_tdata/m_tvalid/m_tlast  output  DSIZE/1/1  downstream beat.
REQ-008 Port m_tready  input  1  downstream ready.
REQ-009 Port m_tcut  output  1  qualifies m_tlast: 1 = forced cut, 0 = original end of packet.

Function
REQ-010 Block SHALL split any input packet longer than MAX_LEN beats into consecutive segments of MAX_LEN beats, with the last segment holding the remainder, so a downstream packet FIFO never waits on a tlast that cannot fit.
REQ-011 Output SHALL be a single register stage: latency 1 cycle from s accept to m_tvalid, full throughput of 1 beat per cycle.
REQ-012 s_tready SHALL equal !m_tvalid || m_tready (combinational); accept = s_tvalid && s_tready.
REQ-013 On accept, the output register SHALL load tdata, m_tvalid=1, m_tlast = s_tlast || (cnt == MAX_LEN-1), and m_tcut = !s_tlast && (cnt == MAX_LEN-1).
REQ-014 If m_tvalid && m_tready and no accept occurs in the same cycle, m_tvalid SHALL clear next cycle; m_tdata/m_tlast/m_tcut SHALL hold while m_tvalid && !m_tready.
REQ-015 Beat counter cnt, width clog2(MAX_LEN+1), SHALL increment on each accept and return to 0 on any accept whose loaded m_tlast = 1; it SHALL never exceed MAX_LEN-1.
REQ-016 s_tlast coinciding with cnt == MAX_LEN-1 SHALL produce one tlast with m_tcut = 0; no empty segment SHALL be emitted.
REQ-017 MAX_LEN = 1 SHALL mark every beat m_tlast = 1, and m_tcut = !s_tlast.
REQ-018 Data order and content SHALL be preserved exactly; no beat SHALL be dropped or duplicated.

Reset
REQ-019 While rst = 1: m_tvalid=0, m_tlast=0, m_tcut=0, m_tdata=0, cnt=0, s_tready=1.
REQ-020 Reset asserted mid-packet SHALL discard the held beat and counter state; the first beat after reset SHALL start a new segment.

Configuration
REQ-021 Macro AXI_STREAM_PACKET_CUTTER_STAT_EN, when defined, SHALL add outputs pkt_cnt[15:0] and cut_cnt[15:0]: saturating counts of output beats with m_tlast && !m_tcut and m_tlast && m_tcut, updated on m_tvalid && m_tready, reset to 0.
REQ-022 Without the macro, these ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-023 MAX_LEN=4, 10-beat packet (data 0..9, tlast on 9), m_tready=1 -> tlast on beats 3, 7, 9; m_tcut=1, 1, 0; back-to-back valid.
REQ-024 MAX_LEN=4, 4-beat packet -> single tlast on beat 3, m_tcut=0, cnt back to 0; next packet starts a fresh count.
REQ-025 MAX_LEN=4, 6-beat packet, m_tready toggling 1,0,0,1 -> outputs stable while stalled, s_tready=0 during stalls, same segmentation as unstalled.
REQ-026 MAX_LEN=1, 3-beat packet -> every beat tlast; m_tcut=1,1,0.
REQ-027 rst pulse after beat 2 of a MAX_LEN=4 packet -> m_tvalid=0 next edge; a following 5-beat packet cuts at beat 3 (counted from 0).
REQ-028 With AXI_STREAM_PACKET_CUTTER_STAT_EN, MAX_LEN=4, 10-beat and 3-beat packets -> pkt_cnt=2, cut_cnt=2.

Source files
------------

// File: rtl/axi_stream_packet_cutter.sv
// AXI-Stream register slice that forces a tlast every MAX_LEN beats, flagging forced cuts on m_tcut.
// Define AXI_STREAM_PACKET_CUTTER_STAT_EN to add saturating pkt_cnt/cut_cnt statistics outputs.
module axi_stream_packet_cutter #(
   parameter int unsigned DSIZE   = 8,
   parameter int unsigned MAX_LEN = 16384
) (
   input  logic             aclk,
   input  logic             rst,
   input  logic [DSIZE-1:0] s_tdata,
   input  logic             s_tvalid,
   input  logic             s_tlast,
   output logic             s_tready,
   output logic [DSIZE-1:0] m_tdata,
   output logic             m_tvalid,
   output logic             m_tlast,
   output logic             m_tcut,
   input  logic             m_tready
`ifdef AXI_STREAM_PACKET_CUTTER_STAT_EN
   ,
   output logic [15:0]      pkt_cnt,
   output logic [15:0]      cut_cnt
`endif
);

   localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LEN - 1);

   logic [DSIZE-1:0] m_tdata_q,  m_tdata_d;
   logic             m_tvalid_q, m_tvalid_d;
   logic             m_tlast_q,  m_tlast_d;
   logic             m_tcut_q,   m_tcut_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;

   logic accept_c;
   logic at_max_c;
   logic seg_end_c;

   // Upstream may push whenever the single output slot is empty or draining this cycle.
   assign s_tready  = !m_tvalid_q || m_tready;
   assign accept_c  = s_tvalid && s_tready;
   assign at_max_c  = (cnt_q == CNT_LAST);
   assign seg_end_c = s_tlast || at_max_c;

   always_comb begin
      m_tdata_d  = m_tdata_q;
      m_tvalid_d = m_tvalid_q;
      m_tlast_d  = m_tlast_q;
      m_tcut_d   = m_tcut_q;
      cnt_d      = cnt_q;
      if (accept_c) begin
         m_tdata_d  = s_tdata;
         m_tvalid_d = 1'b1;
         m_tlast_d  = seg_end_c;
         m_tcut_d   = !s_tlast && at_max_c;
         cnt_d      = seg_end_c ? '0 : cnt_q + CNT_W'(1);
      end else if (m_tready) begin
         m_tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
         m_tdata_q  <= '0;
         m_tvalid_q <= 1'b0;
         m_tlast_q  <= 1'b0;
         m_tcut_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         m_tdata_q  <= m_tdata_d;
         m_tvalid_q <= m_tvalid_d;
         m_tlast_q  <= m_tlast_d;
         m_tcut_q   <= m_tcut_d;
         cnt_q      <= cnt_d;
      end
   end

   assign m_tdata  = m_tdata_q;
   assign m_tvalid = m_tvalid_q;
   assign m_tlast  = m_tlast_q;
   assign m_tcut   = m_tcut_q;

`ifdef AXI_STREAM_PACKET_CUTTER_STAT_EN
   logic [15:0] pkt_cnt_q, pkt_cnt_d;
   logic [15:0] cut_cnt_q, cut_cnt_d;
   logic        out_fire_c;

   assign out_fire_c = m_tvalid_q && m_tready;

   // Saturating end-of-packet and forced-cut counts, taken on the downstream handshake.
   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      cut_cnt_d = cut_cnt_q;
      if (out_fire_c && m_tlast_q && !m_tcut_q && (pkt_cnt_q != 16'hFFFF))
         pkt_cnt_d = pkt_cnt_q + 16'd1;
      if (out_fire_c && m_tlast_q && m_tcut_q && (cut_cnt_q != 16'hFFFF))
         cut_cnt_d = cut_cnt_q + 16'd1;
   end

   always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
         pkt_cnt_q <= '0;
         cut_cnt_q <= '0;
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
         cut_cnt_q <= cut_cnt_d;
      end
   end

   assign pkt_cnt = pkt_cnt_q;
   assign cut_cnt = cut_cnt_q;
`endif

   cnt_in_range_a: assert property (@(posedge aclk) disable iff (rst) cnt_q <= CNT_LAST);

endmodule

// File: tb/tb_axi_stream_packet_cutter.sv
// Bench for axi_stream_packet_cutter: three instances (MAX_LEN 4, 1, 5) share one stimulus stream
// and are checked against directed constants and a packet-position reference model.
module tb_axi_stream_packet_cutter;

   localparam int unsigned DW = 8;

   logic          aclk = 1'b0;
   logic          rst  = 1'b1;
   logic [DW-1:0] s_tdata  = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tlast  = 1'b0;
   logic          m_tready = 1'b0;

   logic          s_tready_w [3];
   logic [DW-1:0] o_data     [3];
   logic          o_valid    [3];
   logic          o_last     [3];
   logic          o_cut      [3];
`ifdef AXI_STREAM_PACKET_CUTTER_STAT_EN
   logic [15:0]   o_pkt      [3];
   logic [15:0]   o_cutc     [3];
`endif

   int unsigned lens [3];
   int n_tests = 0;
   int n_fail  = 0;

   always #5 aclk = ~aclk;

   axi_stream_packet_cutter #(.DSIZE(DW), .MAX_LEN(4)) u_l4 (
      .aclk(aclk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
      .s_tready(s_tready_w[0]), .m_tdata(o_data[0]), .m_tvalid(o_valid[0]), .m_tlast(o_last[0]),
      .m_tcut(o_cut[0]), .m_tready(m_tready)
`ifdef AXI_STREAM_PACKET_CUTTER_STAT_EN
      , .pkt_cnt(o_pkt[0]), .cut_cnt(o_cutc[0])
`endif
   );

   axi_stream_packet_cutter #(.DSIZE(DW), .MAX_LEN(1)) u_l1 (
      .aclk(aclk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
      .s_tready(s_tready_w[1]), .m_tdata(o_data[1]), .m_tvalid(o_valid[1]), .m_tlast(o_last[1]),
      .m_tcut(o_cut[1]), .m_tready(m_tready)
`ifdef AXI_STREAM_PACKET_CUTTER_STAT_EN
      , .pkt_cnt(o_pkt[1]), .cut_cnt(o_cutc[1])
`endif
   );

   axi_stream_packet_cutter #(.DSIZE(DW), .MAX_LEN(5)) u_l5 (
      .aclk(aclk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
      .s_tready(s_tready_w[2]), .m_tdata(o_data[2]), .m_tvalid(o_valid[2]), .m_tlast(o_last[2]),
      .m_tcut(o_cut[2]), .m_tready(m_tready)
`ifdef AXI_STREAM_PACKET_CUTTER_STAT_EN
      , .pkt_cnt(o_pkt[2]), .cut_cnt(o_cutc[2])
`endif
   );

   // Pending input beats with their position inside the original packet.
   logic [DW-1:0] q_data [$];
   bit            q_last [$];
   int            q_idx  [$];
   int            q_len  [$];

   // Reference model of the single output slot.
   bit            exp_v;
   logic [DW-1:0] exp_data;
   bit            exp_last [3];
   bit            exp_cut  [3];

   // A beat closes a segment when it completes a full MAX_LEN run or ends the packet.
   function automatic bit seg_end(int k, int n, int unsigned len);
      return ((k + 1) % int'(len) == 0) || (k == n - 1);
   endfunction

   task automatic add_packet(input int n, input logic [DW-1:0] base);
      for (int k = 0; k < n; k++) begin
         q_data.push_back(DW'(base + DW'(k)));
         q_last.push_back(k == n - 1);
         q_idx.push_back(k);
         q_len.push_back(n);
      end
   endtask

   task automatic drive(input bit rdy, input bit gap);
      m_tready = rdy;
      s_tvalid = (q_data.size() > 0) && !gap;
      if (q_data.size() > 0) begin
         s_tdata = q_data[0];
         s_tlast = q_last[0];
      end else begin
         s_tdata = DW'($urandom);
         s_tlast = 1'($urandom);
      end
      #1;
   endtask

   task automatic step();
      bit acc;
      acc = s_tvalid && (!exp_v || m_tready);
      if (acc) begin
         exp_v    = 1'b1;
         exp_data = q_data[0];
         for (int d = 0; d < 3; d++) begin
            exp_last[d] = seg_end(q_idx[0], q_len[0], lens[d]);
            exp_cut[d]  = exp_last[d] && (q_idx[0] != q_len[0] - 1);
         end
         void'(q_data.pop_front());
         void'(q_last.pop_front());
         void'(q_idx.pop_front());
         void'(q_len.pop_front());
      end else if (m_tready) begin
         exp_v = 1'b0;
      end
      @(posedge aclk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      s_tvalid = 1'b1;
      m_tready = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      for (int d = 0; d < 3; d++) begin
         n_tests++;
         if ({o_valid[d], o_last[d], o_cut[d], o_data[d], s_tready_w[d]} !== {3'b000, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL reset dut%0d: got v%b l%b c%b d%h r%b want v0 l0 c0 d00 r1",
                     d, o_valid[d], o_last[d], o_cut[d], o_data[d], s_tready_w[d]);
         end
      end
      s_tvalid = 1'b0;
      rst = 1'b0;
      exp_v = 1'b0;
      @(posedge aclk);
      #1;
   endtask

   task automatic test_long_cut();
      logic [9:0] el [3];
      logic [9:0] ec [3];
      el[0] = 10'b1010001000; ec[0] = 10'b0010001000;
      el[1] = 10'b1111111111; ec[1] = 10'b0111111111;
      el[2] = 10'b1000010000; ec[2] = 10'b0000010000;
      add_packet(10, 8'h00);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b0);
         n_tests++;
         if (s_tready_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL long_cut s_tready beat%0d: got %b want 1", i, s_tready_w[0]);
         end
         step();
         for (int d = 0; d < 3; d++) begin
            n_tests++;
            if ({o_valid[d], o_data[d], o_last[d], o_cut[d]} !== {1'b1, DW'(i), el[d][i], ec[d][i]}) begin
               n_fail++;
               $display("FAIL long_cut dut%0d beat%0d: got v%b d%h l%b c%b want v1 d%h l%b c%b",
                        d, i, o_valid[d], o_data[d], o_last[d], o_cut[d], DW'(i), el[d][i], ec[d][i]);
            end
         end
      end
      drive(1'b1, 1'b0);
      step();
      for (int d = 0; d < 3; d++) begin
         n_tests++;
         if (o_valid[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL long_cut drain dut%0d: got v%b want v0", d, o_valid[d]);
         end
      end
   endtask

   task automatic test_exact_len();
      logic [6:0] el [3];
      logic [6:0] ec [3];
      logic [DW-1:0] xd;
      el[0] = 7'b1001000; ec[0] = 7'b0000000;
      el[1] = 7'b1111111; ec[1] = 7'b0110111;
      el[2] = 7'b1001000; ec[2] = 7'b0000000;
      add_packet(4, 8'h40);
      add_packet(3, 8'h50);
      for (int j = 0; j < 7; j++) begin
         drive(1'b1, 1'b0);
         step();
         xd = (j < 4) ? DW'(8'h40 + j) : DW'(8'h50 + j - 4);
         for (int d = 0; d < 3; d++) begin
            n_tests++;
            if ({o_valid[d], o_data[d], o_last[d], o_cut[d]} !== {1'b1, xd, el[d][j], ec[d][j]}) begin
               n_fail++;
               $display("FAIL exact_len dut%0d beat%0d: got v%b d%h l%b c%b want v1 d%h l%b c%b",
                        d, j, o_valid[d], o_data[d], o_last[d], o_cut[d], xd, el[d][j], ec[d][j]);
            end
         end
      end
      drive(1'b1, 1'b0);
      step();
   endtask

   task automatic test_stall();
      bit rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int cyc = 0;
      exp_v = 1'b0;
      add_packet(6, 8'h60);
      while ((q_data.size() > 0 || exp_v) && cyc < 100) begin
         drive(rdy_pat[cyc % 4], 1'b0);
         for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (s_tready_w[d] !== (!exp_v || m_tready)) begin
               n_fail++;
               $display("FAIL stall s_tready dut%0d cyc%0d: got %b want %b", d, cyc, s_tready_w[d], !exp_v || m_tready);
            end
            n_tests++;
            if (o_valid[d] !== exp_v) begin
               n_fail++;
               $display("FAIL stall m_tvalid dut%0d cyc%0d: got %b want %b", d, cyc, o_valid[d], exp_v);
            end
            if (exp_v) begin
               n_tests++;
               if ({o_data[d], o_last[d], o_cut[d]} !== {exp_data, exp_last[d], exp_cut[d]}) begin
                  n_fail++;
                  $display("FAIL stall beat dut%0d cyc%0d: got d%h l%b c%b want d%h l%b c%b", d, cyc,
                           o_data[d], o_last[d], o_cut[d], exp_data, exp_last[d], exp_cut[d]);
               end
            end
         end
         step();
         cyc++;
      end
      n_tests++;
      if (cyc >= 100) begin
         n_fail++;
         $display("FAIL stall timeout: %0d beats still pending", q_data.size());
      end
   endtask

   task automatic test_reset_mid();
      add_packet(8, 8'h80);
      repeat (3) begin
         drive(1'b1, 1'b0);
         step();
      end
      rst = 1'b1;
      q_data.delete(); q_last.delete(); q_idx.delete(); q_len.delete();
      s_tvalid = 1'b0;
      @(posedge aclk);
      #1;
      for (int d = 0; d < 3; d++) begin
         n_tests++;
         if ({o_valid[d], o_last[d], o_cut[d], o_data[d], s_tready_w[d]} !== {3'b000, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid dut%0d: got v%b l%b c%b d%h r%b want v0 l0 c0 d00 r1",
                     d, o_valid[d], o_last[d], o_cut[d], o_data[d], s_tready_w[d]);
         end
      end
      rst = 1'b0;
      exp_v = 1'b0;
      add_packet(5, 8'hA0);
      for (int i = 0; i < 5; i++) begin
         logic [4:0] el [3];
         logic [4:0] ec [3];
         el[0] = 5'b11000; ec[0] = 5'b01000;
         el[1] = 5'b11111; ec[1] = 5'b01111;
         el[2] = 5'b10000; ec[2] = 5'b00000;
         drive(1'b1, 1'b0);
         step();
         for (int d = 0; d < 3; d++) begin
            n_tests++;
            if ({o_valid[d], o_data[d], o_last[d], o_cut[d]} !== {1'b1, DW'(8'hA0 + i), el[d][i], ec[d][i]}) begin
               n_fail++;
               $display("FAIL reset_mid pkt dut%0d beat%0d: got v%b d%h l%b c%b want v1 d%h l%b c%b",
                        d, i, o_valid[d], o_data[d], o_last[d], o_cut[d], DW'(8'hA0 + i), el[d][i], ec[d][i]);
            end
         end
      end
      drive(1'b1, 1'b0);
      step();
   endtask

   task automatic test_random();
      int cyc = 0;
      exp_v = 1'b0;
      for (int p = 0; p < 40; p++)
         add_packet(int'($urandom_range(1, 13)), DW'($urandom));
      while ((q_data.size() > 0 || exp_v) && cyc < 2000) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
         for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (s_tready_w[d] !== (!exp_v || m_tready)) begin
               n_fail++;
               $display("FAIL random s_tready dut%0d cyc%0d: got %b want %b", d, cyc, s_tready_w[d], !exp_v || m_tready);
            end
            n_tests++;
            if (o_valid[d] !== exp_v) begin
               n_fail++;
               $display("FAIL random m_tvalid dut%0d cyc%0d: got %b want %b", d, cyc, o_valid[d], exp_v);
            end
            if (exp_v) begin
               n_tests++;
               if ({o_data[d], o_last[d], o_cut[d]} !== {exp_data, exp_last[d], exp_cut[d]}) begin
                  n_fail++;
                  $display("FAIL random beat dut%0d cyc%0d: got d%h l%b c%b want d%h l%b c%b", d, cyc,
                           o_data[d], o_last[d], o_cut[d], exp_data, exp_last[d], exp_cut[d]);
               end
            end
         end
         step();
         cyc++;
      end
      n_tests++;
      if (cyc >= 2000) begin
         n_fail++;
         $display("FAIL random timeout: %0d beats still pending", q_data.size());
      end
   endtask

`ifdef AXI_STREAM_PACKET_CUTTER_STAT_EN
   task automatic test_stats();
      logic [15:0] xp [3];
      logic [15:0] xc [3];
      xp[0] = 16'd2; xc[0] = 16'd2;
      xp[1] = 16'd2; xc[1] = 16'd11;
      xp[2] = 16'd2; xc[2] = 16'd1;
      rst = 1'b1;
      @(posedge aclk);
      #1;
      rst = 1'b0;
      exp_v = 1'b0;
      add_packet(10, 8'h10);
      add_packet(3, 8'h30);
      for (int i = 0; i < 15; i++) begin
         drive(1'b1, 1'b0);
         step();
      end
      for (int d = 0; d < 3; d++) begin
         n_tests++;
         if ({o_pkt[d], o_cutc[d]} !== {xp[d], xc[d]}) begin
            n_fail++;
            $display("FAIL stats dut%0d: got pkt%0d cut%0d want pkt%0d cut%0d", d, o_pkt[d], o_cutc[d], xp[d], xc[d]);
         end
      end
   endtask
`endif

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      lens[0] = 4;
      lens[1] = 1;
      lens[2] = 5;
      test_reset();
      test_long_cut();
      test_exact_len();
      test_stall();
      test_reset_mid();
      test_random();
`ifdef AXI_STREAM_PACKET_CUTTER_STAT_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
